my_tx: RTL and testbench

Byte-serial UART transmitter clocked by the 4× bit-rate clock `CLKP4`. It is the transmit end of the host link, and its frame format matches the companion receiver: start bit, 8 data bits LSB first, optional parity, stop bit(s). A small internal FIFO decouples the command/readout logic from the serial line, so several bytes can be queued back-to-back.

---
 rtl/my_uart_pkg.sv | 21 ++
 rtl/my_tx_fifo.sv | 68 ++++++
 rtl/my_tx.sv | 133 +++++++++++++
 tb/tb_my_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/my_uart_pkg.sv
// Shared UART definitions for the host-link transmitter and receiver:
// frame FSM states, data width and frame-length helper.
package my_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Clock cycles in one complete frame, start bit through last stop bit.
    function automatic int uart_frame_cycles(input int bit_clks, input int stop_bits,
                                             input bit parity_en);
        return (1 + UART_DATA_BITS + (parity_en ? 1 : 0) + stop_bits) * bit_clks;
    endfunction

endpackage

// File: rtl/my_tx_fifo.sv
// Small synchronous byte FIFO in front of the UART transmitter.
// full/empty are registered from the next occupancy; over-full writes are dropped.
module my_tx_fifo
    import my_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] wdata,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic [AW:0]               count_next;
    logic                      do_push;
    logic                      do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/my_tx.sv
// Byte-serial UART transmitter on the 4x bit-rate clock, with a small input FIFO.
// Define MY_TX_PARITY_EN to insert an even-parity bit after D7.
module my_tx
    import my_uart_pkg::*;
#(
    parameter int BIT_CLKS   = 4,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      CLKP4,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [UART_DATA_BITS-1:0] DataIn,
    input  logic                      DataValid,
    output logic                      Full,
    output logic                      Busy,
    output logic                      Tx
);

    localparam int PW = $clog2(BIT_CLKS);

    uart_state_t               state;
    uart_state_t               state_next;
    logic [PW-1:0]             phase;
    logic [3:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      fifo_empty;
    logic                      pop;
    logic                      bit_end;
    logic                      last_data;
    logic                      stop_end;
    logic                      tx_next;
    logic                      busy_next;
`ifdef MY_TX_PARITY_EN
    logic                      par;
`endif

    assign bit_end   = (phase == PW'(BIT_CLKS - 1));
    assign last_data = bit_end && (bit_idx == 4'(UART_DATA_BITS - 1));
    assign stop_end  = bit_end && (bit_idx == 4'(STOP_BITS - 1));
    assign pop       = (state_next == START) && ((state == IDLE) || (state == STOP));

    my_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLKP4),
        .rst  (RST),
        .push (DataValid),
        .pop  (pop),
        .wdata(DataIn),
        .rdata(fifo_head),
        .full (Full),
        .empty(fifo_empty)
    );

    always_ff @(posedge CLKP4) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping EN aborts any frame immediately; STOP chains straight into the next START.
    always_comb begin
        state_next = state;
        if (state != IDLE && !EN) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (EN && !fifo_empty) state_next = START;
                START:  if (bit_end) state_next = DATA;
`ifdef MY_TX_PARITY_EN
                DATA:   if (last_data) state_next = PARITY;
                PARITY: if (bit_end) state_next = STOP;
`else
                DATA:   if (last_data) state_next = STOP;
`endif
                STOP:   if (stop_end) state_next = fifo_empty ? IDLE : START;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = (state == DATA && bit_end) ? shift[1] : shift[0];
`ifdef MY_TX_PARITY_EN
            PARITY:  tx_next = par;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE) || !fifo_empty;
    end

    // Bit timer and bit index restart on every state change, so each bit is exactly BIT_CLKS long.
    always_ff @(posedge CLKP4) begin
        if (RST) begin
            phase   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            Tx      <= 1'b1;
            Busy    <= 1'b0;
`ifdef MY_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            Tx   <= tx_next;
            Busy <= busy_next;
            if (pop) begin
                shift <= fifo_head;
`ifdef MY_TX_PARITY_EN
                par   <= ^fifo_head;
`endif
            end else if (state == DATA && bit_end) begin
                shift <= shift >> 1;
            end
            if (state_next != state || state_next == IDLE) begin
                phase   <= '0;
                bit_idx <= '0;
            end else begin
                phase <= bit_end ? '0 : phase + PW'(1);
                if (bit_end) begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_tx.sv
// Directed self-checking bench for my_tx with default parameters.
// Frame expectations include the parity bit when MY_TX_PARITY_EN is defined.
module tb_my_tx;

    localparam int BIT_CLKS = 4;
`ifdef MY_TX_PARITY_EN
    localparam int FRAME_BITS = 12;
`else
    localparam int FRAME_BITS = 11;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BIT_CLKS;

    logic       CLKP4 = 1'b0;
    logic       RST;
    logic       EN;
    logic [7:0] DataIn;
    logic       DataValid;
    logic       Full;
    logic       Busy;
    logic       Tx;

    int total = 0;
    int bad   = 0;

    my_tx #(
        .BIT_CLKS  (4),
        .STOP_BITS (2),
        .FIFO_DEPTH(4)
    ) dut (
        .CLKP4    (CLKP4),
        .RST      (RST),
        .EN       (EN),
        .DataIn   (DataIn),
        .DataValid(DataValid),
        .Full     (Full),
        .Busy     (Busy),
        .Tx       (Tx)
    );

    always #5 CLKP4 = ~CLKP4;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepClock(input int n = 1);
        repeat (n) begin
            @(posedge CLKP4);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid);
        DataIn    = data;
        DataValid = valid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Serial level of frame bit j: start, D0..D7, optional parity, then stop bits.
    function automatic logic expBit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef MY_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called just after the start edge; returns just after the edge ending the frame.
    task automatic checkFrame(input string tag, input logic [7:0] b);
        for (int i = 0; i < FRAME_CYC; i++) begin
            checkOutput($sformatf("%s_tx%0d", tag, i), {31'd0, Tx}, {31'd0, expBit(b, i / BIT_CLKS)});
            checkOutput($sformatf("%s_busy%0d", tag, i), {31'd0, Busy}, 32'd1);
            stepClock();
        end
    endtask

    task automatic checkQuiet(input string tag, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            stepClock();
            if (Tx !== 1'b1) lows++;
        end
        checkOutput(tag, lows, 0);
    endtask

    task automatic writeByte(input logic [7:0] b);
        applyStimulus(b, 1'b1);
        stepClock();
        applyStimulus(8'h00, 1'b0);
        stepClock();
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        applyStimulus(8'h00, 1'b0);
        stepClock(3);
        checkOutput("rst_tx", {31'd0, Tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_full", {31'd0, Full}, 32'd0);
        RST = 1'b0;
        EN  = 1'b1;
        stepClock();

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55, 1'b1);
        stepClock();
        applyStimulus(8'h00, 1'b0);
        checkOutput("lat_tx_k", {31'd0, Tx}, 32'd1);
        checkOutput("lat_busy_k", {31'd0, Busy}, 32'd0);
        stepClock();
        checkFrame("b55", 8'h55);
        checkOutput("b55_end_tx", {31'd0, Tx}, 32'd1);
        checkOutput("b55_end_busy", {31'd0, Busy}, 32'd0);
        stepClock(3);

        $display("[TB] back-to-back 0x00 0xFF");
        applyStimulus(8'h00, 1'b1);
        stepClock();
        applyStimulus(8'hFF, 1'b1);
        stepClock();
        applyStimulus(8'h00, 1'b0);
        checkFrame("b2b00", 8'h00);
        checkFrame("b2bFF", 8'hFF);
        checkOutput("b2b_end_tx", {31'd0, Tx}, 32'd1);
        checkOutput("b2b_end_busy", {31'd0, Busy}, 32'd0);
        stepClock(3);

        $display("[TB] overflow with EN low");
        EN = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1);
            stepClock();
            checkOutput($sformatf("ovf_full%0d", i), {31'd0, Full}, (i >= 4) ? 32'd1 : 32'd0);
        end
        checkOutput("ovf_busy_q", {31'd0, Busy}, 32'd1);
        checkOutput("ovf_tx_q", {31'd0, Tx}, 32'd1);
        applyStimulus(8'h99, 1'b1);
        EN = 1'b1;
        stepClock();
        applyStimulus(8'h00, 1'b0);
        checkOutput("ovf_full_fall", {31'd0, Full}, 32'd0);
        checkFrame("ovf01", 8'h01);
        checkFrame("ovf02", 8'h02);
        checkFrame("ovf03", 8'h03);
        checkFrame("ovf04", 8'h04);
        checkOutput("ovf_end_busy", {31'd0, Busy}, 32'd0);
        checkQuiet("ovf_no_extra", 60);

        $display("[TB] EN abort during D3");
        applyStimulus(8'h3C, 1'b1);
        stepClock();
        applyStimulus(8'h7E, 1'b1);
        stepClock();
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i <= 17; i++) begin
            checkOutput($sformatf("ab3C_tx%0d", i), {31'd0, Tx}, {31'd0, expBit(8'h3C, i / BIT_CLKS)});
            if (i < 17) stepClock();
        end
        EN = 1'b0;
        stepClock();
        checkOutput("ab_tx_hi", {31'd0, Tx}, 32'd1);
        checkOutput("ab_busy_q", {31'd0, Busy}, 32'd1);
        checkQuiet("ab_quiet", 10);
        checkOutput("ab_busy_q2", {31'd0, Busy}, 32'd1);
        EN = 1'b1;
        stepClock();
        checkFrame("ab7E", 8'h7E);
        checkOutput("ab_end_tx", {31'd0, Tx}, 32'd1);
        checkOutput("ab_end_busy", {31'd0, Busy}, 32'd0);
        stepClock(3);

`ifdef MY_TX_PARITY_EN
        $display("[TB] parity frames");
        writeByte(8'h07);
        checkFrame("par07", 8'h07);
        stepClock(2);
        writeByte(8'h03);
        checkFrame("par03", 8'h03);
        stepClock(2);
`else
        $display("[TB] single byte 0xC3");
        writeByte(8'hC3);
        checkFrame("bC3", 8'hC3);
        stepClock(2);
`endif

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, 1'b1);
        stepClock();
        applyStimulus(8'h11, 1'b1);
        stepClock();
        applyStimulus(8'h00, 1'b0);
        stepClock(10);
        RST = 1'b1;
        stepClock();
        checkOutput("mrst_tx", {31'd0, Tx}, 32'd1);
        checkOutput("mrst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("mrst_full", {31'd0, Full}, 32'd0);
        RST = 1'b0;
        checkQuiet("mrst_no_frame", 60);
        checkOutput("mrst_busy_after", {31'd0, Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
